// File: rtl/vc_flow_scheduler_if.sv
// Purpose : FIFO-side handshake bundle for vc_flow_scheduler (empties, heads, occupancies, strobes, pauses).
// Latency : n/a (wiring only); valid_* lag pop_* by one cycle inside the scheduler.
// Backpr. : pause_* are the almost-full flags the scheduler derives from the occupancies carried here.
//
// Signals:
//   main_empty, vc0_empty, vc1_empty   FIFO empty flags            (slave -> master)
//   vc0_head_dest, vc1_head_dest       head word bit 5, 0=D0 1=D1  (slave -> master)
//   vc0/vc1/d0/d1_count                FIFO occupancies, CW bits   (slave -> master)
//   pop_main, pop_vc0, pop_vc1         read strobes                (master -> slave)
//   valid_main, valid_vc0, valid_vc1   registered read strobes     (master -> slave)
//   pause_vc0/vc1/d0/d1                almost-full flags           (master -> slave)
interface vc_flow_scheduler_if #(
  parameter int CW = 4
);
  logic          main_empty;
  logic          vc0_empty;
  logic          vc1_empty;
  logic          vc0_head_dest;
  logic          vc1_head_dest;
  logic [CW-1:0] vc0_count;
  logic [CW-1:0] vc1_count;
  logic [CW-1:0] d0_count;
  logic [CW-1:0] d1_count;
  logic          pop_main;
  logic          valid_main;
  logic          pop_vc0;
  logic          pop_vc1;
  logic          valid_vc0;
  logic          valid_vc1;
  logic          pause_vc0;
  logic          pause_vc1;
  logic          pause_d0;
  logic          pause_d1;

  // Scheduler side.
  modport master (
    input  main_empty, vc0_empty, vc1_empty,
    input  vc0_head_dest, vc1_head_dest,
    input  vc0_count, vc1_count, d0_count, d1_count,
    output pop_main, valid_main, pop_vc0, pop_vc1, valid_vc0, valid_vc1,
    output pause_vc0, pause_vc1, pause_d0, pause_d1
  );

  // FIFO / datapath side.
  modport slave (
    output main_empty, vc0_empty, vc1_empty,
    output vc0_head_dest, vc1_head_dest,
    output vc0_count, vc1_count, d0_count, d1_count,
    input  pop_main, valid_main, pop_vc0, pop_vc1, valid_vc0, valid_vc1,
    input  pause_vc0, pause_vc1, pause_d0, pause_d1
  );
endinterface

// File: rtl/vc_flow_scheduler.sv
// Purpose : flow controller for Main -> demux -> VC0/VC1 -> mux -> D0/D1; sequencing FSM, pops, pauses, weighted RR.
// Latency : pops and pauses are combinational; valid_* follow pop_* by one clock.
// Backpr. : pop_main stalls while either VC FIFO is almost full; a VC is skipped while its head's destination is almost full.
//
// Ports:
//   clk, reset_L          clock; synchronous active-low reset
//   init, afull_thr_in    hold/enter INIT and load the almost-full threshold (0 or >DEPTH loads DEPTH)
//   fifo (master)         FIFO status in, pop/valid/pause out (see vc_flow_scheduler_if)
//   afull_thr, state      active threshold; one-hot state RESET=0001 INIT=0010 IDLE=0100 ACTIVE=1000
//   grant_cnt_d0/d1       per-destination VC grant counters, present only with SCHED_STATS_EN defined
module vc_flow_scheduler #(
  parameter  int DEPTH      = 8,
  parameter  int VC0_WEIGHT = 2,
  parameter  int AFULL_DEF  = 6,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic [CW-1:0]        afull_thr_in,
  vc_flow_scheduler_if.master  fifo,
  output logic [CW-1:0]        afull_thr,
  output logic [3:0]           state
`ifdef SCHED_STATS_EN
  ,
  output logic [7:0]           grant_cnt_d0,
  output logic [7:0]           grant_cnt_d1
`endif
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_t;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_DEF);
  localparam logic [2:0]    WEIGHT_C = 3'(VC0_WEIGHT);

  state_t        state_q;
  state_t        state_d;
  logic [2:0]    wcnt_q;
  logic [2:0]    wcnt_d;
  logic          any_pending;
  logic [CW-1:0] thr_clamped;

  logic pause_vc0_c, pause_vc1_c, pause_d0_c, pause_d1_c;
  logic pop_main_c, grant0, grant1;
  logic elig0, elig1;
  logic valid_main_q, valid_vc0_q, valid_vc1_q;

  assign any_pending = !fifo.main_empty || !fifo.vc0_empty || !fifo.vc1_empty;

  // A zero or oversized threshold would either pause forever or never pause
  // on a full FIFO; DEPTH keeps the path moving and still pauses when full.
  assign thr_clamped = (afull_thr_in == '0 || afull_thr_in > DEPTH_C) ? DEPTH_C : afull_thr_in;

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RESET) begin
      state_d = ST_INIT;
    end else if (init) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT:   state_d = ST_IDLE;
        ST_IDLE:   if (any_pending) state_d = ST_ACTIVE;
        ST_ACTIVE: if (!any_pending) state_d = ST_IDLE;
        default:   state_d = ST_RESET;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    pause_vc0_c = 1'b0;
    pause_vc1_c = 1'b0;
    pause_d0_c  = 1'b0;
    pause_d1_c  = 1'b0;
    pop_main_c  = 1'b0;
    elig0       = 1'b0;
    elig1       = 1'b0;
    grant0      = 1'b0;
    grant1      = 1'b0;
    // Default clear covers VC1 grants, VC1 not eligible and non-ACTIVE states.
    wcnt_d      = 3'd0;

    if (state_q != ST_RESET) begin
      pause_vc0_c = (fifo.vc0_count >= afull_thr);
      pause_vc1_c = (fifo.vc1_count >= afull_thr);
      pause_d0_c  = (fifo.d0_count  >= afull_thr);
      pause_d1_c  = (fifo.d1_count  >= afull_thr);
    end

    if (state_q == ST_ACTIVE) begin
      // The demux may route to either VC, so both must have room.
      pop_main_c = !fifo.main_empty && !pause_vc0_c && !pause_vc1_c;
      elig0 = !fifo.vc0_empty && !(fifo.vc0_head_dest ? pause_d1_c : pause_d0_c);
      elig1 = !fifo.vc1_empty && !(fifo.vc1_head_dest ? pause_d1_c : pause_d0_c);

      if (elig0 && elig1) begin
        if (wcnt_q < WEIGHT_C) begin
          grant0 = 1'b1;
          wcnt_d = wcnt_q + 3'd1;
        end else begin
          grant1 = 1'b1;
        end
      end else if (elig0) begin
        grant0 = 1'b1;
      end else if (elig1) begin
        grant1 = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      afull_thr    <= AFULL_C;
      wcnt_q       <= 3'd0;
      valid_main_q <= 1'b0;
      valid_vc0_q  <= 1'b0;
      valid_vc1_q  <= 1'b0;
    end else begin
      valid_main_q <= pop_main_c;
      valid_vc0_q  <= grant0;
      valid_vc1_q  <= grant1;
      wcnt_q       <= wcnt_d;
      if (state_q == ST_INIT) begin
        afull_thr <= thr_clamped;
      end
    end
  end

  assign state           = state_q;
  assign fifo.pop_main   = pop_main_c;
  assign fifo.pop_vc0    = grant0;
  assign fifo.pop_vc1    = grant1;
  assign fifo.valid_main = valid_main_q;
  assign fifo.valid_vc0  = valid_vc0_q;
  assign fifo.valid_vc1  = valid_vc1_q;
  assign fifo.pause_vc0  = pause_vc0_c;
  assign fifo.pause_vc1  = pause_vc1_c;
  assign fifo.pause_d0   = pause_d0_c;
  assign fifo.pause_d1   = pause_d1_c;

  // ---------------------------------------------------------------- grant statistics
`ifdef SCHED_STATS_EN
  logic hit_d0;
  logic hit_d1;

  // Only one VC is granted per cycle, so at most one counter steps.
  assign hit_d0 = (grant0 && !fifo.vc0_head_dest) || (grant1 && !fifo.vc1_head_dest);
  assign hit_d1 = (grant0 &&  fifo.vc0_head_dest) || (grant1 &&  fifo.vc1_head_dest);

  always_ff @(posedge clk) begin
    if (!reset_L || state_q == ST_INIT) begin
      grant_cnt_d0 <= 8'd0;
      grant_cnt_d1 <= 8'd0;
    end else begin
      if (hit_d0 && grant_cnt_d0 != 8'hFF) grant_cnt_d0 <= grant_cnt_d0 + 8'd1;
      if (hit_d1 && grant_cnt_d1 != 8'hFF) grant_cnt_d1 <= grant_cnt_d1 + 8'd1;
    end
  end
`else
  // Statistics build option off: no grant counters.
`endif

endmodule

// File: doc/vc_flow_scheduler.md
Name: vc_flow_scheduler

Overview:
- Central flow controller for the Main FIFO -> demux -> VC0/VC1 FIFOs -> mux -> D0/D1 FIFO path.
- Sequences the path through an init/idle/active state machine and generates pop strobes for Main, VC0 and VC1.
- Derives pause (almost-full) flags from FIFO occupancy against programmable thresholds.
- Arbitrates the shared mux output between VC0 and VC1 using weighted round-robin.

Parameters:
- DEPTH, 8, entries per FIFO; occupancy inputs are CW = $clog2(DEPTH+1) bits wide.
- VC0_WEIGHT, 2, consecutive VC0 grants allowed while VC1 is eligible before VC1 must be served (1..7).
- AFULL_DEF, 6, almost-full threshold loaded at reset.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset_L  in  1  synchronous, active-low reset.
- init  in  1  1 = enter or stay in INIT and load thresholds.
- afull_thr_in  in  CW  almost-full threshold sampled in INIT.
- main_empty  in  1  Main FIFO empty.
- vc0_empty, vc1_empty  in  1 each  VC FIFO empty.
- vc0_head_dest, vc1_head_dest  in  1 each  bit 5 of VC head word; 0 = D0, 1 = D1.
- vc0_count, vc1_count, d0_count, d1_count  in  CW each  FIFO occupancies.
- pop_main  out  1  read strobe to Main FIFO.
- valid_main  out  1  registered pop_main; qualifies demux input.
- pop_vc0, pop_vc1  out  1 each  VC read strobes.
- valid_vc0, valid_vc1  out  1 each  registered pop_vcX; qualify mux inputs.
- pause_vc0, pause_vc1, pause_d0, pause_d1  out  1 each  almost-full flags.
- afull_thr  out  CW  active threshold register.
- state  out  4  one-hot: RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000.

Behaviour:
- Single clock; reset is synchronous and active-low.
- While reset_L=0 at a clock edge:
  - state = RESET; afull_thr = AFULL_DEF; weight counter wcnt = 0.
  - valid_main, valid_vc0 and valid_vc1 = 0.
  - Combinational pops are forced to 0 in RESET.
- Reset asserted mid-operation aborts any grant on that same edge; in-flight valid_* clear.
- State transitions, evaluated in priority order:
  - RESET -> INIT on the first edge with reset_L=1.
  - Any state with init=1 -> INIT.
  - INIT: afull_thr <= afull_thr_in on every edge. init=0 -> IDLE.
  - IDLE -> ACTIVE when any of main_empty, vc0_empty, vc1_empty is 0.
  - ACTIVE -> IDLE when all three are 1.
- Threshold rule: afull_thr_in = 0 or > DEPTH loads DEPTH, so the path can never deadlock.
- Pause flags are combinational: pause_X = (X_count >= afull_thr). They are valid in every state except RESET, where they are 0.
- Main pop: pop_main = ACTIVE & !main_empty & !pause_vc0 & !pause_vc1.
- Read latency is 1: valid_main <= pop_main on the next edge. valid_vcX likewise follows pop_vcX.
- VC eligibility: eligX = ACTIVE & !vcX_empty & !pause_d[vcX_head_dest].
- At most one of pop_vc0 and pop_vc1 is high per cycle.
- Arbitration:
  - Only one VC eligible -> that VC is granted.
  - Both eligible and wcnt < VC0_WEIGHT -> VC0 granted, wcnt++.
  - Both eligible and wcnt = VC0_WEIGHT -> VC1 granted, wcnt <= 0.
  - wcnt also clears on any VC1 grant, whenever VC1 is not eligible, and in non-ACTIVE states.
- pop_main and a VC pop may assert in the same cycle.
- Occupancy equal to the threshold asserts pause.
- A full FIFO (count = DEPTH) therefore always pauses.

Optional Feature:
- Macro: SCHED_STATS_EN.
- Defined: adds outputs grant_cnt_d0 and grant_cnt_d1 (8 bits each).
  - Each counts VC grants whose head_dest matches that destination.
  - Counters saturate at 255.
  - Cleared by reset and on every cycle spent in INIT.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset and init: reset_L=0 for 2 cycles, then 1 with init=1 and afull_thr_in=5 for 2 cycles, then init=0 -> state goes 0001, 0010, 0010, 0100; afull_thr=5; all pops and valids 0 throughout.
- Threshold clamp: init with afull_thr_in=0, then with 12 (DEPTH=8) -> afull_thr=8 in both cases.
- Main pause: ACTIVE, main_empty=0, vc1_count=5 with afull_thr=5 -> pause_vc1=1 and pop_main=0. Drop vc1_count to 4 -> pop_main=1 that cycle and valid_main=1 the next.
- Weighted RR: both VCs non-empty with head_dest=0 and d0_count=0 for 9 cycles, VC0_WEIGHT=2 -> grant sequence VC0,VC0,VC1,VC0,VC0,VC1,VC0,VC0,VC1; never both pops high.
- Destination pause: vc0_head_dest=1, d1_count=6, afull_thr=6, vc1 head_dest=0 -> pop_vc0=0 and pop_vc1=1 every cycle while VC1 is non-empty.
- Mid-operation reset: pop_vc0=1 in ACTIVE, reset_L=0 for one edge -> next cycle state=0001, valid_vc0=0, wcnt=0. With SCHED_STATS_EN, grant_cnt_d0=0.
